// File: rtl/snake_step_ctrl.sv
// Per-move sequencer: next head cell, wall check, body-ring update, tail erase and head plot.
// Latency: normal move done 5 cycles after step, grow move 3 cycles; a wall hit parks in DEAD after 2.
// Backpressure: none; step is honoured only in IDLE and is otherwise ignored.
module snake_step_ctrl #(
    parameter int          ADDR_W       = 7,
    parameter int          MAX_LEN      = 128,
    parameter logic [7:0]  START_X      = 8'd80,
    parameter logic [6:0]  START_Y      = 7'd60,
    parameter logic [2:0]  SNAKE_COLOUR = 3'b010,
    parameter logic [2:0]  BG_COLOUR    = 3'b000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              step,
    input  logic [1:0]        dir_req,
    input  logic              grow,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [14:0]       ram_wdata,
    output logic              ram_we,
    input  logic [14:0]       ram_rdata,
    output logic [7:0]        x_out,
    output logic [6:0]        y_out,
    output logic [2:0]        colour,
    output logic              plot,
    output logic              done,
    output logic [1:0]        status,
    output logic [ADDR_W:0]   length
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CALC,
        S_TAIL_RD,
        S_TAIL_PLOT,
        S_HEAD_WR,
        S_HEAD_PLOT,
        S_DEAD
    } state_t;

    localparam logic [1:0]        DIR_UP    = 2'b00;
    localparam logic [1:0]        DIR_DOWN  = 2'b01;
    localparam logic [1:0]        DIR_LEFT  = 2'b10;
    localparam logic [1:0]        DIR_RIGHT = 2'b11;
    localparam logic [7:0]        X_MAX     = 8'd159;
    localparam logic [6:0]        Y_MAX     = 7'd119;
    localparam logic [ADDR_W:0]   MAX_LEN_L = MAX_LEN[ADDR_W:0];
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_n;
    logic              init_arm;
    logic [ADDR_W-1:0] head_ptr;
    logic [ADDR_W-1:0] tail_ptr;
    logic [ADDR_W:0]   len_q;
    logic [1:0]        cur_dir;
    logic              grow_pend;
    logic              grow_move;
    logic [7:0]        hx;
    logic [6:0]        hy;

    logic [7:0]        nx;
    logic [6:0]        ny;
    logic              hit_wall;
    logic              can_grow;
    logic              reverse_req;

    assign length      = len_q;
    assign can_grow    = grow_pend && (len_q < MAX_LEN_L);
    assign reverse_req = ((dir_req ^ cur_dir) == 2'b01);

    always_comb begin
        nx = hx;
        ny = hy;
        case (cur_dir)
            DIR_UP:   ny = hy - 7'd1;
            DIR_DOWN: ny = hy + 7'd1;
            DIR_LEFT: nx = hx - 8'd1;
            default:  nx = hx + 8'd1;
        endcase
    end

    assign hit_wall = ((cur_dir == DIR_UP)    && (hy == 7'd0))  ||
                      ((cur_dir == DIR_DOWN)  && (hy == Y_MAX)) ||
                      ((cur_dir == DIR_LEFT)  && (hx == 8'd0))  ||
                      ((cur_dir == DIR_RIGHT) && (hx == X_MAX));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
        end else begin
            state <= state_n;
        end
    end

    // INIT only fires once init_arm is set, so the strobes stay low while reset is held.
    always_comb begin
        state_n   = state;
        ram_addr  = tail_ptr;
        ram_wdata = {nx, ny};
        ram_we    = 1'b0;
        x_out     = hx;
        y_out     = hy;
        colour    = SNAKE_COLOUR;
        plot      = 1'b0;
        done      = 1'b0;
        status    = 2'b01;
        case (state)
            S_INIT: begin
                if (init_arm) begin
                    ram_we    = 1'b1;
                    ram_addr  = '0;
                    ram_wdata = {START_X, START_Y};
                    plot      = 1'b1;
                    x_out     = START_X;
                    y_out     = START_Y;
                    state_n   = S_IDLE;
                end
            end
            S_IDLE: begin
                status = 2'b00;
                if (step) begin
                    state_n = S_CALC;
                end
            end
            S_CALC: begin
                if (hit_wall) begin
                    state_n = S_DEAD;
                end else if (can_grow) begin
                    state_n = S_HEAD_WR;
                end else begin
                    state_n = S_TAIL_RD;
                end
            end
            S_TAIL_RD: begin
                state_n = S_TAIL_PLOT;
            end
            S_TAIL_PLOT: begin
                // RAM read data is registered inside the RAM, so this is not a combinational input path.
                plot    = 1'b1;
                x_out   = ram_rdata[14:7];
                y_out   = ram_rdata[6:0];
                colour  = BG_COLOUR;
                state_n = S_HEAD_WR;
            end
            S_HEAD_WR: begin
                ram_we   = 1'b1;
                ram_addr = head_ptr + PTR_ONE;
                state_n  = S_HEAD_PLOT;
            end
            S_HEAD_PLOT: begin
                plot    = 1'b1;
                done    = 1'b1;
                state_n = S_IDLE;
            end
            S_DEAD: begin
                status = 2'b10;
            end
            default: begin
                state_n = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_arm  <= 1'b0;
            head_ptr  <= '0;
            tail_ptr  <= '0;
            len_q     <= LEN_ONE;
            cur_dir   <= DIR_RIGHT;
            grow_pend <= 1'b0;
            grow_move <= 1'b0;
            hx        <= START_X;
            hy        <= START_Y;
        end else begin
            init_arm <= 1'b1;
            if ((state == S_IDLE) && step && !reverse_req) begin
                cur_dir <= dir_req;
            end
            if (state == S_CALC) begin
                grow_move <= can_grow;
            end
            if (state == S_TAIL_PLOT) begin
                tail_ptr <= tail_ptr + PTR_ONE;
            end
            if (state == S_HEAD_WR) begin
                head_ptr <= head_ptr + PTR_ONE;
                hx       <= nx;
                hy       <= ny;
                if (grow_move) begin
                    len_q <= len_q + LEN_ONE;
                end
            end
            // A new grow pulse wins over either clear condition.
            if (grow) begin
                grow_pend <= 1'b1;
            end else if (((state == S_CALC) && !hit_wall && can_grow) || (len_q == MAX_LEN_L)) begin
                grow_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Scoreboard bench for snake_step_ctrl on a small 8-entry ring: moves, grow, reversal, wrap, reset and wall.
module tb_snake_step_ctrl;
    localparam int         AW = 3;
    localparam int         ML = 8;
    localparam logic [2:0] SN = 3'b010;
    localparam logic [2:0] BG = 3'b000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          step = 1'b0;
    logic [1:0]    dir_req = 2'b00;
    logic          grow = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [14:0]   ram_wdata;
    logic          ram_we;
    logic [14:0]   ram_rdata;
    logic [7:0]    x_out;
    logic [6:0]    y_out;
    logic [2:0]    colour;
    logic          plot;
    logic          done;
    logic [1:0]    status;
    logic [AW:0]   length;

    snake_step_ctrl #(.ADDR_W(AW), .MAX_LEN(ML)) dut (
        .clk(clk), .reset_n(reset_n), .step(step), .dir_req(dir_req), .grow(grow),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot), .done(done),
        .status(status), .length(length)
    );

    always #5 clk = ~clk;

    int pcnt = 0;
    always @(posedge clk) pcnt <= pcnt + 1;

    logic [14:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        int          cyc;
        logic [14:0] v0;
        logic [14:0] v1;
    } ev_t;

    ev_t plot_q[$];
    ev_t wr_q[$];
    ev_t done_q[$];
    int  checks = 0;
    int  errors = 0;

    logic [7:0]  mx;
    logic [6:0]  my;
    logic [1:0]  mdir;
    int          mlen;
    int          mhp;
    logic [14:0] body[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_plot(input int c, input logic [7:0] x, input logic [6:0] y, input logic [2:0] col);
        ev_t e;
        e.cyc = c; e.v0 = {x, y}; e.v1 = {12'd0, col};
        plot_q.push_back(e);
    endtask

    task automatic push_wr(input int c, input int a, input logic [7:0] x, input logic [6:0] y);
        ev_t e;
        e.cyc = c; e.v0 = 15'(a); e.v1 = {x, y};
        wr_q.push_back(e);
    endtask

    task automatic push_done(input int c);
        ev_t e;
        e.cyc = c; e.v0 = '0; e.v1 = '0;
        done_q.push_back(e);
    endtask

    // p0 is the posedge count seen just after the step edge; cycle k of the move has pcnt = p0+k-1.
    task automatic exp_norm(input int p0, input logic [7:0] tx, input logic [6:0] ty,
                            input int a, input logic [7:0] x, input logic [6:0] y);
        push_plot(p0 + 2, tx, ty, BG);
        push_wr(p0 + 3, a, x, y);
        push_plot(p0 + 4, x, y, SN);
        push_done(p0 + 4);
    endtask

    task automatic exp_grow(input int p0, input int a, input logic [7:0] x, input logic [6:0] y);
        push_wr(p0 + 1, a, x, y);
        push_plot(p0 + 2, x, y, SN);
        push_done(p0 + 2);
    endtask

    task automatic monitor_cycle();
        ev_t e;
        if (plot === 1'b1) begin
            checks++;
            if (plot_q.size() == 0) begin
                errors++;
                $display("FAIL plot_unexpected: got (%0d,%0d) colour %0b at cycle %0d, expected no plot",
                         x_out, y_out, colour, pcnt);
            end else begin
                e = plot_q.pop_front();
                if (e.cyc != pcnt || e.v0 !== {x_out, y_out} || e.v1[2:0] !== colour) begin
                    errors++;
                    $display("FAIL plot_event: got (%0d,%0d) colour %0b cycle %0d, expected (%0d,%0d) colour %0b cycle %0d",
                             x_out, y_out, colour, pcnt, e.v0[14:7], e.v0[6:0], e.v1[2:0], e.cyc);
                end
            end
        end
        if (ram_we === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL ram_we_unexpected: got addr %0d data (%0d,%0d) at cycle %0d, expected no write",
                         ram_addr, ram_wdata[14:7], ram_wdata[6:0], pcnt);
            end else begin
                e = wr_q.pop_front();
                if (e.cyc != pcnt || e.v0 !== 15'(ram_addr) || e.v1 !== ram_wdata) begin
                    errors++;
                    $display("FAIL ram_write: got addr %0d (%0d,%0d) cycle %0d, expected addr %0d (%0d,%0d) cycle %0d",
                             ram_addr, ram_wdata[14:7], ram_wdata[6:0], pcnt, e.v0, e.v1[14:7], e.v1[6:0], e.cyc);
                end
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: got done at cycle %0d, expected none", pcnt);
            end else begin
                e = done_q.pop_front();
                if (e.cyc != pcnt) begin
                    errors++;
                    $display("FAIL done_cycle: got cycle %0d expected cycle %0d", pcnt, e.cyc);
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (status !== 2'b00 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (status !== 2'b00) begin
            errors++;
            $display("FAIL %s_timeout: status %0b after %0d cycles, expected 00", name, status, n);
        end
    endtask

    task automatic issue_step(input logic [1:0] d, output int p0);
        @(posedge clk); #1;
        step = 1'b1;
        dir_req = d;
        @(posedge clk); #1;
        p0 = pcnt;
        step = 1'b0;
    endtask

    task automatic pulse_grow();
        @(posedge clk); #1;
        grow = 1'b1;
        @(posedge clk); #1;
        grow = 1'b0;
    endtask

    task automatic release_reset();
        int r;
        @(negedge clk); #2;
        r = pcnt;
        push_plot(r + 1, 8'd80, 7'd60, SN);
        push_wr(r + 1, 0, 8'd80, 7'd60);
        reset_n = 1'b1;
        mx = 8'd80; my = 7'd60; mdir = 2'b11; mlen = 1; mhp = 0;
        body.delete();
        body.push_back({8'd80, 7'd60});
        wait_idle("init");
    endtask

    // Game-level model: reversal ignored, grow adds a cell while below the cap, otherwise the tail is erased.
    task automatic model_move(input logic [1:0] d, input bit g);
        int          p0;
        logic [1:0]  nd;
        logic [7:0]  nxm;
        logic [6:0]  nym;
        logic [14:0] t;
        if (g) pulse_grow();
        issue_step(d, p0);
        nd = ((d == 2'b00 && mdir == 2'b01) || (d == 2'b01 && mdir == 2'b00) ||
              (d == 2'b10 && mdir == 2'b11) || (d == 2'b11 && mdir == 2'b10)) ? mdir : d;
        nxm = mx; nym = my;
        case (nd)
            2'b00:   nym = my - 7'd1;
            2'b01:   nym = my + 7'd1;
            2'b10:   nxm = mx - 8'd1;
            default: nxm = mx + 8'd1;
        endcase
        mhp = (mhp + 1) % (1 << AW);
        if (g && mlen < ML) begin
            exp_grow(p0, mhp, nxm, nym);
            mlen++;
        end else begin
            t = body.pop_front();
            exp_norm(p0, t[14:7], t[6:0], mhp, nxm, nym);
        end
        body.push_back({nxm, nym});
        mx = nxm; my = nym; mdir = nd;
        wait_idle("move");
    endtask

    initial begin
        int p0;
        fork
            forever begin
                @(negedge clk);
                monitor_cycle();
            end
        join_none

        #1 reset_n = 1'b0;
        #1;
        chk("reset_plot", int'(plot), 0);
        chk("reset_ram_we", int'(ram_we), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_status", int'(status), 1);
        chk("reset_length", int'(length), 1);
        repeat (3) @(negedge clk);
        release_reset();
        chk("idle_length", int'(length), 1);

        // Right move from (80,60)
        issue_step(2'b11, p0);
        exp_norm(p0, 8'd80, 7'd60, 1, 8'd81, 7'd60);
        wait_idle("right");

        // Grow plus a left request while moving right: kept right
        pulse_grow();
        issue_step(2'b10, p0);
        exp_grow(p0, 2, 8'd82, 7'd60);
        wait_idle("grow");
        chk("grow_length", int'(length), 2);

        // Turn up, then a down request which is a reversal
        issue_step(2'b00, p0);
        exp_norm(p0, 8'd81, 7'd60, 3, 8'd82, 7'd59);
        wait_idle("up");
        issue_step(2'b01, p0);
        exp_norm(p0, 8'd82, 7'd60, 4, 8'd82, 7'd58);
        wait_idle("rev_up");
        chk("len_after_turns", int'(length), 2);

        mx = 8'd82; my = 7'd58; mdir = 2'b00; mlen = 2; mhp = 4;
        body.delete();
        body.push_back({8'd82, 7'd59});
        body.push_back({8'd82, 7'd58});

        // Twenty grow moves: saturation at 8 and head pointer wrap
        for (int i = 0; i < 20; i++) begin
            model_move((i % 2 == 1) ? 2'b00 : 2'b11, 1'b1);
        end
        chk("sat_length", int'(length), 8);

        // Reset during TAIL_PLOT
        issue_step(2'b11, p0);
        @(posedge clk);
        @(posedge clk); #2;
        chk("mid_plot_before", int'(plot), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_plot_after", int'(plot), 0);
        chk("mid_ram_we", int'(ram_we), 0);
        chk("mid_status", int'(status), 1);
        chk("mid_length", int'(length), 1);
        repeat (2) @(posedge clk);
        release_reset();
        chk("reinit_length", int'(length), 1);

        // March right to the wall
        for (int i = 0; i < 79; i++) begin
            model_move(2'b11, 1'b0);
        end
        chk("wall_x_reached", int'(mx), 159);
        issue_step(2'b11, p0);
        @(negedge clk);
        chk("wall_calc_status", int'(status), 1);
        @(negedge clk);
        chk("wall_dead_status", int'(status), 2);
        pulse_grow();
        issue_step(2'b00, p0);
        issue_step(2'b10, p0);
        repeat (10) @(negedge clk);
        chk("dead_sticky", int'(status), 2);
        chk("dead_length", int'(length), 1);

        repeat (3) @(negedge clk);
        chk("plot_q_empty", plot_q.size(), 0);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
